// File: rtl/alu_exec_unit.sv
// Iterative execute-stage ALU: single-cycle arithmetic/logic, bit-serial shifts.
// Valid/ready handshake on both sides; one operation in flight at a time.
module alu_exec_unit #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_work;
  logic [SHW-1:0]  r_cnt;
  logic            r_left;
  logic            r_fill;

  logic            w_accept;
  logic            w_is_shift;
  logic [SHW-1:0]  w_amt;
  logic [XLEN-1:0] w_alu;

  // Shift codes return op_a unchanged here; that is the shift-by-0 result.
  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] ctrl,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = a + b;
    case (ctrl)
      OP_SUB:                 r = a - b;
      OP_AND:                 r = a & b;
      OP_OR:                  r = a | b;
      OP_XOR:                 r = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: r = a;
      OP_SLT:                 r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:                r = {{(XLEN-1){1'b0}}, (a < b)};
      default:                r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] w,
                                                input logic left,
                                                input logic fill);
    return left ? {w[XLEN-2:0], 1'b0} : {fill, w[XLEN-1:1]};
  endfunction

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign w_amt      = op_b[SHW-1:0];
  assign w_alu      = alu_op(alu_ctrl, op_a, op_b);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = (w_is_shift && (w_amt != '0)) ? SHIFT : DONE;
      SHIFT:   if (r_cnt == SHW'(1)) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_left <= (alu_ctrl == OP_SLL);
        // SRA replicates the original sign bit for every position shifted in.
        r_fill <= (alu_ctrl == OP_SRA) ? op_a[XLEN-1] : 1'b0;
        if (w_is_shift && (w_amt != '0)) begin
          r_work <= op_a;
          r_cnt  <= w_amt;
        end else begin
          r_work <= w_alu;
        end
      end else if (r_state == SHIFT) begin
        r_work <= shift_one(r_work, r_left, r_fill);
        r_cnt  <= r_cnt - SHW'(1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_work;
  assign zero      = (r_work == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, random ops
// against a behavioural model, backpressure and mid-shift reset sequences.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_ctrl = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned amt;
    amt = b & 32'd31;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << amt;
      4'd6: return a >> amt;
      4'd7: return $unsigned($signed(a) >>> amt);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
    int unsigned amt;
    amt = b & 32'd31;
    if ((c == 4'd5 || c == 4'd6 || c == 4'd7) && amt != 0) return int'(amt) + 1;
    return 1;
  endfunction

  // Issue one op, wait for its result (bounded), then drain it.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result; z = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    logic        stale;
    logic [3:0]  c;
    logic [31:0] a, b;

    vecs.push_back('{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1});
    vecs.push_back('{4'h1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1});
    vecs.push_back('{4'h7, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32});
    vecs.push_back('{4'h6, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 32});
    vecs.push_back('{4'h5, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 32});
    vecs.push_back('{4'h5, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1});
    vecs.push_back('{4'h6, 32'h80000000, 32'hFFFFFFE3, 32'h10000000, 1'b0, 4});
    vecs.push_back('{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1});
    vecs.push_back('{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1});
    vecs.push_back('{4'hF, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1});
    vecs.push_back('{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1});
    vecs.push_back('{4'h3, 32'h0000FFFF, 32'h00FF0000, 32'h00FFFFFF, 1'b0, 1});
    vecs.push_back('{4'h4, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1});
    vecs.push_back('{4'h7, 32'h7FFFFFFF, 32'd4,        32'h07FFFFFF, 1'b0, 5});
    vecs.push_back('{4'hA, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1});

    #12;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, res, z, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d_zero", i), 64'(z), 64'(vecs[i].exp_zero));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
    end

    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op(c, a, b, res, z, lat);
      check($sformatf("rnd%0d_result", i), 64'(res), 64'(ref_alu(c, a, b)));
      check($sformatf("rnd%0d_zero", i), 64'(z), 64'(ref_alu(c, a, b) == 32'd0));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(ref_lat(c, b)));
    end

    // Backpressure: result held, further requests ignored while stalled.
    alu_ctrl = 4'h0; op_a = 32'd10; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      alu_ctrl = 4'($urandom_range(0, 4)); op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", i), 64'(result), 64'd30);
      check($sformatf("bp_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("bp_hold%0d_out_valid", i), 64'(out_valid), 64'd1);
    end
    alu_ctrl = 4'h4; op_a = 32'h00001234; op_b = 32'h000000FF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_drain_in_ready", 64'(in_ready), 64'd1);
    check("bp_drain_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_out_valid", 64'(out_valid), 64'd1);
    check("bp_next_result", 64'(result), 64'h000012CB);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a shift.
    alu_ctrl = 4'h5; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("arst_no_stale_valid", 64'(stale), 64'd0);
    run_op(4'h0, 32'd7, 32'd8, res, z, lat);
    check("arst_add_result", 64'(res), 64'd15);
    check("arst_add_latency", 64'(lat), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
